// File: rtl/keys_debounce.sv
// keys_debounce: synchronise and debounce KEY/SW pads; optional key-press IRQ when KEYS_EDGE_IRQ_EN is defined
module keys_debounce #(
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 16,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic [3:0] key_raw,
    input  logic [9:0] sw_raw,
`ifdef KEYS_EDGE_IRQ_EN
    output logic [3:0] key_evt,
    input  logic [3:0] evt_clr,
    output logic       irq,
`endif
    output logic [3:0] key,
    output logic [9:0] sw
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [3:0] KEY_INV = KEY_ACTIVE_LOW != 0 ? 4'hF : 4'h0;
    logic [13:0] sync1, sync2, s, stable, stable_d;
    logic [PW-1:0] pcnt;
    logic tick;
    logic [CW-1:0] cnt [14];
    logic [CW-1:0] cnt_d [14];
    assign s = {sync2[13:4], sync2[3:0] ^ KEY_INV};
    assign tick = pcnt == P_LAST;
    assign key = stable[3:0];
    assign sw = stable[13:4];
    // two-flop synchroniser for all pad inputs, keys in the low nibble
    always_ff @(posedge pclk or negedge presetn)
        if (!presetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sw_raw, key_raw};
            sync2 <= sync1;
        end
    // free-running prescaler producing the one-cycle debounce sample tick
    always_ff @(posedge pclk or negedge presetn)
        if (!presetn) pcnt <= '0;
        else pcnt <= tick ? '0 : pcnt + 1'b1;
    // per-bit decision: restart on agreement, advance on tick, accept at the last count
    always_comb begin
        stable_d = stable;
        for (int b = 0; b < 14; b++) begin
            cnt_d[b] = '0;
            if (s[b] != stable[b])
                cnt_d[b] = !tick ? cnt[b] : (cnt[b] == C_LAST ? '0 : cnt[b] + 1'b1);
            if (s[b] != stable[b] && tick && cnt[b] == C_LAST)
                stable_d[b] = s[b];
        end
    end
    // debounced levels and their counters
    always_ff @(posedge pclk or negedge presetn)
        if (!presetn) begin
            stable <= '0;
            cnt <= '{default: '0};
        end else begin
            stable <= stable_d;
            cnt <= cnt_d;
        end
`ifdef KEYS_EDGE_IRQ_EN
    logic [3:0] evt_d;
    assign evt_d = (key_evt & ~evt_clr) | (stable_d[3:0] & ~stable[3:0]);
    // sticky press flags set on a debounced 0->1 (set beats clear) and their OR
    always_ff @(posedge pclk or negedge presetn)
        if (!presetn) begin
            key_evt <= '0;
            irq <= 1'b0;
        end else begin
            key_evt <= evt_d;
            irq <= |evt_d;
        end
`endif
endmodule

// File: tb/tb_keys_debounce.sv
// tb_keys_debounce: directed bench for keys_debounce (TICK_DIV=4, DEBOUNCE_TICKS=3), edge IRQ checks when KEYS_EDGE_IRQ_EN is defined
module tb_keys_debounce;
    logic pclk = 1'b0;
    logic presetn = 1'b0;
    logic [3:0] key_raw, key;
    logic [9:0] sw_raw, sw;
`ifdef KEYS_EDGE_IRQ_EN
    logic [3:0] key_evt, evt_clr;
    logic irq;
`endif
    int tests = 0;
    int fails = 0;
    int n;
    logic ok;
    always #5 pclk = ~pclk;
    keys_debounce #(.TICK_DIV(4), .DEBOUNCE_TICKS(3), .KEY_ACTIVE_LOW(1)) dut (
        .pclk(pclk),
        .presetn(presetn),
        .key_raw(key_raw),
        .sw_raw(sw_raw),
`ifdef KEYS_EDGE_IRQ_EN
        .key_evt(key_evt),
        .evt_clr(evt_clr),
        .irq(irq),
`endif
        .key(key),
        .sw(sw)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic check_range(input string tag, input int v, input int lo, input int hi);
        tests++;
        assert (v >= lo && v <= hi) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
        end
    endtask
    task automatic step();
        @(posedge pclk);
        #1;
    endtask
    task automatic steps(input int k);
        repeat (k) step();
    endtask
    task automatic settle(input string tag, input logic [3:0] kr, input logic [9:0] sr,
                          input logic [3:0] ke, input logic [9:0] se);
        key_raw = kr;
        sw_raw = sr;
        steps(20);
        check({tag, "_key"}, key, ke);
        check({tag, "_sw"}, sw, se);
    endtask
    initial begin
        key_raw = 4'hF;
        sw_raw = 10'h3FF;
`ifdef KEYS_EDGE_IRQ_EN
        evt_clr = 4'h0;
`endif
        steps(3);
        check("rst_key", key, 0);
        check("rst_sw", sw, 0);
        presetn = 1'b1;
        n = 0;
        ok = 1'b1;
        while (sw !== 10'h3FF && n < 30) begin
            step();
            n++;
            if (key !== 4'h0) ok = 1'b0;
        end
        check_range("pwrup_lat", n, 10, 15);
        check("pwrup_sw", sw, 10'h3FF);
        check("pwrup_key", ok, 1);
        settle("t1done", 4'hF, 10'h0, 4'h0, 10'h0);
        ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) key_raw[0] = ~key_raw[0];
            step();
            if (key[0] !== 1'b0) ok = 1'b0;
        end
        key_raw[0] = 1'b0;
        check("bounce_key0", ok, 1);
        n = 0;
        while (key[0] !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check_range("bounce_lat", n, 10, 15);
        check("bounce_key", key, 4'h1);
        ok = 1'b1;
        repeat (20) begin
            step();
            if (key[0] !== 1'b1) ok = 1'b0;
        end
        check("bounce_once", ok, 1);
        settle("t2done", 4'hF, 10'h0, 4'h0, 10'h0);
        sw_raw[3] = 1'b1;
        ok = 1'b1;
        repeat (6) begin
            step();
            if (sw[3] !== 1'b0) ok = 1'b0;
        end
        sw_raw[3] = 1'b0;
        repeat (20) begin
            step();
            if (sw[3] !== 1'b0) ok = 1'b0;
        end
        check("glitch_sw3", ok, 1);
        check("glitch_cnt", dut.cnt[7], 0);
        sw_raw[9] = 1'b1;
        key_raw[3] = 1'b0;
        n = 0;
        while (key === 4'h0 && sw === 10'h0 && n < 30) begin
            step();
            n++;
        end
        check_range("same_lat", n, 10, 15);
        check("same_key", key, 4'h8);
        check("same_sw", sw, 10'h200);
        sw_raw[1] = 1'b1;
        steps(8);
        check("pre_rst_sw", sw, 10'h200);
        presetn = 1'b0;
        #1;
        check("midrst_sw", sw, 0);
        check("midrst_key", key, 0);
        check("midrst_cnt", dut.cnt[5], 0);
        steps(2);
        presetn = 1'b1;
        n = 0;
        while (sw[1] !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check_range("fresh_lat", n, 10, 15);
        check("fresh_sw", sw, 10'h202);
        check("fresh_key", key, 4'h8);
`ifdef KEYS_EDGE_IRQ_EN
        settle("t6pre", 4'hF, 10'h0, 4'h0, 10'h0);
        evt_clr = 4'hF;
        step();
        evt_clr = 4'h0;
        check("evt_init", key_evt, 0);
        check("irq_init", irq, 0);
        key_raw[2] = 1'b0;
        n = 0;
        while (key[2] !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check_range("press_lat", n, 10, 15);
        check("press_evt", key_evt, 4'h4);
        check("press_irq", irq, 1);
        evt_clr[2] = 1'b1;
        step();
        evt_clr = 4'h0;
        check("clr_evt", key_evt, 0);
        check("clr_irq", irq, 0);
        key_raw[2] = 1'b1;
        n = 0;
        while (key[2] !== 1'b0 && n < 30) begin
            step();
            n++;
        end
        check_range("release_lat", n, 10, 15);
        check("release_evt", key_evt, 0);
        check("release_irq", irq, 0);
        key_raw[2] = 1'b0;
        evt_clr[2] = 1'b1;
        n = 0;
        while (key[2] !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        evt_clr = 4'h0;
        check_range("setclr_lat", n, 10, 15);
        check("setclr_evt", key_evt, 4'h4);
        check("setclr_irq", irq, 1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
